alu_control_mc: RTL



---
 rtl/alu_control_mc.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_control_mc.sv
// rtl/alu_control_mc.sv - registered ALU control decode with multiply/divide latency tracking
module alu_control_mc #(
    parameter int CTRL_W   = 5,
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32,
    parameter int CNT_W    = 6
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iValid,
    output logic              oReady,
    input  logic              iFlush,
    input  logic [1:0]        iALUOp,
    input  logic [5:0]        iOpcode,
    input  logic [5:0]        iFunct,
    input  logic [4:0]        iRt,
    output logic [CTRL_W-1:0] oControlSignal,
    output logic              oValid,
    output logic              oInvalid,
    output logic              oBusy,
    output logic              oHiLoWe
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;

    if (MULT_LAT < 1) begin : g_bad_mult_lat
        $error("alu_control_mc: MULT_LAT must be at least 1");
    end
    if (DIV_LAT < 1) begin : g_bad_div_lat
        $error("alu_control_mc: DIV_LAT must be at least 1");
    end
    if ((64'd1 << CNT_W) <= 64'(MAX_LAT)) begin : g_bad_cnt_w
        $error("alu_control_mc: CNT_W too narrow for the configured latencies");
    end
    if (CTRL_W < 5) begin : g_bad_ctrl_w
        $error("alu_control_mc: CTRL_W must hold the 5-bit operation codes");
    end

    // ALU operation codes; 0 is reserved for "no legal decode"
    localparam logic [4:0] OP_ADD   = 5'd1;
    localparam logic [4:0] OP_SUB   = 5'd2;
    localparam logic [4:0] OP_AND   = 5'd3;
    localparam logic [4:0] OP_OR    = 5'd4;
    localparam logic [4:0] OP_XOR   = 5'd5;
    localparam logic [4:0] OP_NOR   = 5'd6;
    localparam logic [4:0] OP_SLT   = 5'd7;
    localparam logic [4:0] OP_SLTU  = 5'd8;
    localparam logic [4:0] OP_SLL   = 5'd9;
    localparam logic [4:0] OP_SRL   = 5'd10;
    localparam logic [4:0] OP_SRA   = 5'd11;
    localparam logic [4:0] OP_SLLV  = 5'd12;
    localparam logic [4:0] OP_SRLV  = 5'd13;
    localparam logic [4:0] OP_SRAV  = 5'd14;
    localparam logic [4:0] OP_MFHI  = 5'd15;
    localparam logic [4:0] OP_MTHI  = 5'd16;
    localparam logic [4:0] OP_MFLO  = 5'd17;
    localparam logic [4:0] OP_MTLO  = 5'd18;
    localparam logic [4:0] OP_MULT  = 5'd19;
    localparam logic [4:0] OP_MULTU = 5'd20;
    localparam logic [4:0] OP_DIV   = 5'd21;
    localparam logic [4:0] OP_DIVU  = 5'd22;
    localparam logic [4:0] OP_LUI   = 5'd23;
    localparam logic [4:0] OP_SGT   = 5'd24;

    // MIPS R-type funct fields
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2a;
    localparam logic [5:0] FN_SLTU  = 6'h2b;

    // MIPS opcodes and REGIMM rt selectors
    localparam logic [5:0] OPC_REGIMM = 6'h01;
    localparam logic [5:0] OPC_JAL    = 6'h03;
    localparam logic [5:0] OPC_BLEZ   = 6'h06;
    localparam logic [5:0] OPC_BGTZ   = 6'h07;
    localparam logic [5:0] OPC_ADDI   = 6'h08;
    localparam logic [5:0] OPC_ADDIU  = 6'h09;
    localparam logic [5:0] OPC_SLTI   = 6'h0a;
    localparam logic [5:0] OPC_SLTIU  = 6'h0b;
    localparam logic [5:0] OPC_ANDI   = 6'h0c;
    localparam logic [5:0] OPC_ORI    = 6'h0d;
    localparam logic [5:0] OPC_XORI   = 6'h0e;
    localparam logic [5:0] OPC_LUI    = 6'h0f;
    localparam logic [4:0] RT_BLTZ    = 5'h00;
    localparam logic [4:0] RT_BGEZ    = 5'h01;
    localparam logic [4:0] RT_BLTZAL  = 5'h10;
    localparam logic [4:0] RT_BGEZAL  = 5'h11;

    // Counter reloads: the counter reaches zero in the last busy cycle
    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_LAT - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [4:0]       dec_op;
    logic             dec_bad;
    logic             dec_multi;
    logic             dec_div;
    logic             accept;
    logic             cnt_zero;

    // Instruction decode: ALUOp selects fixed add/sub, funct table or opcode table
    always_comb begin
        dec_op    = 5'd0;
        dec_bad   = 1'b0;
        dec_multi = 1'b0;
        dec_div   = 1'b0;
        case (iALUOp)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                case (iFunct)
                    FN_SLL:           dec_op = OP_SLL;
                    FN_SRL:           dec_op = OP_SRL;
                    FN_SRA:           dec_op = OP_SRA;
                    FN_SLLV:          dec_op = OP_SLLV;
                    FN_SRLV:          dec_op = OP_SRLV;
                    FN_SRAV:          dec_op = OP_SRAV;
                    FN_MFHI:          dec_op = OP_MFHI;
                    FN_MTHI:          dec_op = OP_MTHI;
                    FN_MFLO:          dec_op = OP_MFLO;
                    FN_MTLO:          dec_op = OP_MTLO;
                    FN_MULT:  begin dec_op = OP_MULT;  dec_multi = 1'b1; end
                    FN_MULTU: begin dec_op = OP_MULTU; dec_multi = 1'b1; end
                    FN_DIV:   begin dec_op = OP_DIV;   dec_multi = 1'b1; dec_div = 1'b1; end
                    FN_DIVU:  begin dec_op = OP_DIVU;  dec_multi = 1'b1; dec_div = 1'b1; end
                    FN_ADD, FN_ADDU:  dec_op = OP_ADD;
                    FN_SUB, FN_SUBU:  dec_op = OP_SUB;
                    FN_AND:           dec_op = OP_AND;
                    FN_OR:            dec_op = OP_OR;
                    FN_XOR:           dec_op = OP_XOR;
                    FN_NOR:           dec_op = OP_NOR;
                    FN_SLT:           dec_op = OP_SLT;
                    FN_SLTU:          dec_op = OP_SLTU;
                    default:          dec_bad = 1'b1;
                endcase
            end
            2'b11: begin
                case (iOpcode)
                    OPC_ADDI, OPC_ADDIU: dec_op = OP_ADD;
                    OPC_SLTI:            dec_op = OP_SLT;
                    OPC_SLTIU:           dec_op = OP_SLTU;
                    OPC_ANDI:            dec_op = OP_AND;
                    OPC_ORI:             dec_op = OP_OR;
                    OPC_XORI:            dec_op = OP_XOR;
                    OPC_LUI:             dec_op = OP_LUI;
                    OPC_JAL:             dec_op = OP_AND;
                    OPC_BLEZ, OPC_BGTZ: begin
                        if (iRt == 5'd0) dec_op = OP_SGT;
                        else             dec_bad = 1'b1;
                    end
                    OPC_REGIMM: begin
                        case (iRt)
                            RT_BLTZ, RT_BGEZ, RT_BLTZAL, RT_BGEZAL: dec_op = OP_SLT;
                            default:                                dec_bad = 1'b1;
                        endcase
                    end
                    default: dec_bad = 1'b1;
                endcase
            end
            default: dec_bad = 1'b1;
        endcase
    end

    assign cnt_zero = (cnt == '0);

    // Handshake, busy/strobe outputs and next state; reset and flush suppress accept and strobe
    always_comb begin
        oReady    = 1'b0;
        oHiLoWe   = 1'b0;
        oBusy     = (state == S_BUSY);
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: oReady = !iRST;
            S_BUSY: begin
                oReady  = cnt_zero && !iFlush && !iRST;
                oHiLoWe = cnt_zero && !iFlush && !iRST;
            end
            default: ;
        endcase
        accept = iValid && oReady && !iFlush;
        if (iFlush) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end else if (accept && dec_multi) begin
            state_nxt = S_BUSY;
            cnt_nxt   = dec_div ? DIV_LD : MULT_LD;
        end else if (state == S_BUSY) begin
            if (cnt_zero) state_nxt = S_IDLE;
            else          cnt_nxt   = cnt - 1'b1;
        end
    end

    // State and latency counter register
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Decode result register; the control word holds until the next accept
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oControlSignal <= '0;
            oValid         <= 1'b0;
            oInvalid       <= 1'b0;
        end else if (accept) begin
            oControlSignal <= CTRL_W'(dec_op);
            oValid         <= 1'b1;
            oInvalid       <= dec_bad;
        end else begin
            oValid         <= 1'b0;
            oInvalid       <= 1'b0;
        end
    end

endmodule
